// File: rtl/maze_pkg.sv
// maze_pkg: shared constants for the maze game-logic slice.
//   - direction bit positions in the move_req pulse vector
//   - movement engine state encoding
//   - default map geometry / start / goal, shared with vga_controller and
//     the map ROM instance so all three agree on one maze
package maze_pkg;

    // move_req bit positions
    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    // engine state encoding
    localparam logic [2:0] ST_IDLE_ENC  = 3'd0;
    localparam logic [2:0] ST_WAIT_ENC  = 3'd1;
    localparam logic [2:0] ST_CHECK_ENC = 3'd2;
    localparam logic [2:0] ST_DEAD_ENC  = 3'd3;
    localparam logic [2:0] ST_DONE_ENC  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_WAIT  = ST_WAIT_ENC,
        ST_CHECK = ST_CHECK_ENC,
        ST_DEAD  = ST_DEAD_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_e;

    // default maze geometry
    localparam int MAZE_MAP_W   = 30;
    localparam int MAZE_MAP_H   = 21;
    localparam int MAZE_POS_W   = 8;
    localparam int MAZE_START_X = 0;
    localparam int MAZE_START_Y = 20;
    localparam int MAZE_GOAL_X  = 29;
    localparam int MAZE_GOAL_Y  = 0;

endpackage

// File: rtl/maze_move_arbiter.sv
// maze_move_arbiter: combinational direction select and target computation.
// Ports:
//   move_req  [3:0]      direction pulses (up, down, left, right)
//   pos_x/y   [POS_W]    current player position
//   req_valid            any direction requested
//   tgt_x/y   [POS_W]    target cell of the winning direction
//   in_bounds            target lies inside the map (no wrap)
module maze_move_arbiter
    import maze_pkg::*;
#(
    parameter int MAP_W = MAZE_MAP_W,
    parameter int MAP_H = MAZE_MAP_H,
    parameter int POS_W = MAZE_POS_W
) (
    input  logic [3:0]       move_req,
    input  logic [POS_W-1:0] pos_x,
    input  logic [POS_W-1:0] pos_y,
    output logic             req_valid,
    output logic [POS_W-1:0] tgt_x,
    output logic [POS_W-1:0] tgt_y,
    output logic             in_bounds
);

    localparam logic [POS_W-1:0] X_MAX = POS_W'(MAP_W - 1);
    localparam logic [POS_W-1:0] Y_MAX = POS_W'(MAP_H - 1);

    // Fixed priority up > down > left > right.
    always_comb begin
        req_valid = |move_req;
        tgt_x     = pos_x;
        tgt_y     = pos_y;
        in_bounds = 1'b0;
        if (move_req[DIR_UP]) begin
            tgt_y     = pos_y - POS_W'(1);
            in_bounds = (pos_y != '0);
        end else if (move_req[DIR_DOWN]) begin
            tgt_y     = pos_y + POS_W'(1);
            in_bounds = (pos_y != Y_MAX);
        end else if (move_req[DIR_LEFT]) begin
            tgt_x     = pos_x - POS_W'(1);
            in_bounds = (pos_x != '0);
        end else if (move_req[DIR_RIGHT]) begin
            tgt_x     = pos_x + POS_W'(1);
            in_bounds = (pos_x != X_MAX);
        end
    end

endmodule

// File: rtl/maze_move_engine.sv
// maze_move_engine: player movement, collision and win engine.
// A direction pulse in IDLE latches the target, points the map ROM at the
// target row, waits ROM_LATENCY cycles, then commits, rejects or kills.
// Ports:
//   clk, reset      clock, async active-high reset
//   move_req [3:0]  direction pulses, ignored unless IDLE
//   restart         sync pulse back to the start state, top priority
//   map_addr        ROM row address;  map_data  ROM row (1 = wall)
//   player_x/y      current position
//   lost, won       sticky end-of-game flags
//   busy            move under evaluation
//   move_count      committed moves (only built with MAZE_MOVE_COUNT_EN,
//                   saturating at 16'hFFFF; tied to 0 otherwise)
module maze_move_engine
    import maze_pkg::*;
#(
    parameter int MAP_W       = MAZE_MAP_W,
    parameter int MAP_H       = MAZE_MAP_H,
    parameter int POS_W       = MAZE_POS_W,
    parameter int START_X     = MAZE_START_X,
    parameter int START_Y     = MAZE_START_Y,
    parameter int GOAL_X      = MAZE_GOAL_X,
    parameter int GOAL_Y      = MAZE_GOAL_Y,
    parameter int ROM_LATENCY = 1,
    parameter int WALL_LETHAL = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               move_req,
    input  logic                     restart,
    output logic [$clog2(MAP_H)-1:0] map_addr,
    input  logic [MAP_W-1:0]         map_data,
    output logic [POS_W-1:0]         player_x,
    output logic [POS_W-1:0]         player_y,
    output logic                     lost,
    output logic                     won,
    output logic                     busy,
    output logic [15:0]              move_count
);

    localparam int AW  = $clog2(MAP_H);
    localparam int XW  = (MAP_W > 1) ? $clog2(MAP_W) : 1;
    localparam int WCW = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

    localparam logic [POS_W-1:0] SX = POS_W'(START_X);
    localparam logic [POS_W-1:0] SY = POS_W'(START_Y);
    localparam logic [POS_W-1:0] GX = POS_W'(GOAL_X);
    localparam logic [POS_W-1:0] GY = POS_W'(GOAL_Y);
    localparam logic [WCW-1:0]   WAIT_LAST = WCW'(ROM_LATENCY - 1);

    state_e           state_q, state_d;
    logic [POS_W-1:0] px_q, px_d, py_q, py_d;
    logic [POS_W-1:0] tx_q, tx_d, ty_q, ty_d;
    logic [AW-1:0]    addr_q, addr_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic             lost_q, lost_d, won_q, won_d, busy_q, busy_d;
`ifdef MAZE_MOVE_COUNT_EN
    logic [15:0]      cnt_q, cnt_d;
`endif

    logic             req_valid, in_bounds;
    logic [POS_W-1:0] arb_x, arb_y;
    logic             wall_hit;

    maze_move_arbiter #(
        .MAP_W (MAP_W),
        .MAP_H (MAP_H),
        .POS_W (POS_W)
    ) u_arb (
        .move_req  (move_req),
        .pos_x     (px_q),
        .pos_y     (py_q),
        .req_valid (req_valid),
        .tgt_x     (arb_x),
        .tgt_y     (arb_y),
        .in_bounds (in_bounds)
    );

    // tx_q is always in range, so the narrowed index never exceeds MAP_W-1.
    assign wall_hit = map_data[XW'(tx_q)];

    always_comb begin
        state_d = state_q;
        px_d    = px_q;
        py_d    = py_q;
        tx_d    = tx_q;
        ty_d    = ty_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        lost_d  = lost_q;
        won_d   = won_q;
        busy_d  = busy_q;
`ifdef MAZE_MOVE_COUNT_EN
        cnt_d   = cnt_q;
`endif
        if (restart) begin
            // Discards any in-flight move.
            state_d = ST_IDLE;
            px_d    = SX;
            py_d    = SY;
            tx_d    = SX;
            ty_d    = SY;
            addr_d  = AW'(START_Y);
            wait_d  = '0;
            lost_d  = 1'b0;
            won_d   = 1'b0;
            busy_d  = 1'b0;
`ifdef MAZE_MOVE_COUNT_EN
            cnt_d   = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Out-of-bounds requests are dropped without going busy.
                    if (req_valid && in_bounds) begin
                        tx_d    = arb_x;
                        ty_d    = arb_y;
                        addr_d  = AW'(arb_y);
                        wait_d  = '0;
                        busy_d  = 1'b1;
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_q == WAIT_LAST) state_d = ST_CHECK;
                    else                     wait_d  = wait_q + WCW'(1);
                end
                ST_CHECK: begin
                    busy_d = 1'b0;
                    if (!wall_hit) begin
                        px_d = tx_q;
                        py_d = ty_q;
`ifdef MAZE_MOVE_COUNT_EN
                        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
                        if (tx_q == GX && ty_q == GY) begin
                            won_d   = 1'b1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (WALL_LETHAL != 0) begin
                        lost_d  = 1'b1;
                        state_d = ST_DEAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                default: ; // DEAD / DONE hold until restart or reset
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            px_q    <= SX;
            py_q    <= SY;
            tx_q    <= SX;
            ty_q    <= SY;
            addr_q  <= AW'(START_Y);
            wait_q  <= '0;
            lost_q  <= 1'b0;
            won_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef MAZE_MOVE_COUNT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            px_q    <= px_d;
            py_q    <= py_d;
            tx_q    <= tx_d;
            ty_q    <= ty_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            lost_q  <= lost_d;
            won_q   <= won_d;
            busy_q  <= busy_d;
`ifdef MAZE_MOVE_COUNT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign map_addr = addr_q;
    assign player_x = px_q;
    assign player_y = py_q;
    assign lost     = lost_q;
    assign won      = won_q;
    assign busy     = busy_q;
`ifdef MAZE_MOVE_COUNT_EN
    assign move_count = cnt_q;
`else
    assign move_count = 16'd0;
`endif

endmodule

// File: tb/tb_maze_move_engine.sv
// Bench for maze_move_engine: one lethal-wall and one safe-wall instance
// driven by the same stimulus, each with its own synchronous ROM model.
module tb_maze_move_engine;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  move_req = 4'd0;
    logic        restart = 1'b0;
    logic [29:0] map_mem [0:20];

    logic [4:0]  ma0, ma1;
    logic [29:0] md0, md1;
    logic [7:0]  px0, py0, px1, py1;
    logic        lost0, won0, busy0, lost1, won1, busy1;
    logic [15:0] cnt0, cnt1;

    int errors = 0;
    int checks = 0;

`ifdef MAZE_MOVE_COUNT_EN
    localparam int CE = 1;
`else
    localparam int CE = 0;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) begin
        md0 <= map_mem[ma0];
        md1 <= map_mem[ma1];
    end

    maze_move_engine #(.WALL_LETHAL(1)) u_lethal (
        .clk(clk), .reset(reset), .move_req(move_req), .restart(restart),
        .map_addr(ma0), .map_data(md0), .player_x(px0), .player_y(py0),
        .lost(lost0), .won(won0), .busy(busy0), .move_count(cnt0));

    maze_move_engine #(.WALL_LETHAL(0)) u_safe (
        .clk(clk), .reset(reset), .move_req(move_req), .restart(restart),
        .map_addr(ma1), .map_data(md1), .player_x(px1), .player_y(py1),
        .lost(lost1), .won(won1), .busy(busy1), .move_count(cnt1));

    task automatic clear_map();
        for (int r = 0; r < 21; r++) map_mem[r] = '0;
    endtask

    // Drive a one-cycle pulse; returns 1ns after the edge that samples it.
    task automatic press(input logic [3:0] d);
        @(posedge clk); #1 move_req = d;
        @(posedge clk); #1 move_req = 4'd0;
    endtask

    // press and let a full ROM_LATENCY=1 evaluation finish
    task automatic move(input logic [3:0] d);
        press(d);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        @(posedge clk); #1 restart = 1'b1;
        @(posedge clk); #1 restart = 1'b0;
    endtask

    task automatic test_reset();
        clear_map();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (px0 !== 8'd0)  begin errors++; $display("FAIL reset_x got=%0d exp=0", px0); end
        checks++; if (py0 !== 8'd20) begin errors++; $display("FAIL reset_y got=%0d exp=20", py0); end
        checks++; if ({lost0, won0, busy0} !== 3'b000) begin errors++; $display("FAIL reset_flags got=%b exp=000", {lost0, won0, busy0}); end
        checks++; if (ma0 !== 5'd20) begin errors++; $display("FAIL reset_addr got=%0d exp=20", ma0); end
        checks++; if (cnt0 !== 16'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
    endtask

    task automatic test_move_right();
        press(4'b1000);
        // edge N+1: WAIT
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL right_busy1 got=%b exp=1", busy0); end
        checks++; if (ma0 !== 5'd20) begin errors++; $display("FAIL right_addr got=%0d exp=20", ma0); end
        @(posedge clk); #1; // N+2: CHECK
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL right_busy2 got=%b exp=1", busy0); end
        checks++; if (px0 !== 8'd0) begin errors++; $display("FAIL right_early_x got=%0d exp=0", px0); end
        @(posedge clk); #1; // N+3: commit
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL right_busy3 got=%b exp=0", busy0); end
        checks++; if ({px0, py0} !== {8'd1, 8'd20}) begin errors++; $display("FAIL right_pos got=(%0d,%0d) exp=(1,20)", px0, py0); end
        checks++; if (cnt0 !== 16'(CE)) begin errors++; $display("FAIL right_count got=%0d exp=%0d", cnt0, CE); end
    endtask

    task automatic test_priority();
        move(4'b0101);
        checks++; if ({px0, py0} !== {8'd1, 8'd19}) begin errors++; $display("FAIL prio_pos got=(%0d,%0d) exp=(1,19)", px0, py0); end
        checks++; if (cnt0 !== 16'(2 * CE)) begin errors++; $display("FAIL prio_count got=%0d exp=%0d", cnt0, 2 * CE); end
        do_restart();
        checks++; if ({px0, py0, cnt0} !== {8'd0, 8'd20, 16'd0}) begin errors++; $display("FAIL prio_restart got=(%0d,%0d,%0d) exp=(0,20,0)", px0, py0, cnt0); end
    endtask

    task automatic test_wall();
        map_mem[20][1] = 1'b1;
        move(4'b1000);
        checks++; if (lost0 !== 1'b1) begin errors++; $display("FAIL wall_lethal_lost got=%b exp=1", lost0); end
        checks++; if ({px0, py0} !== {8'd0, 8'd20}) begin errors++; $display("FAIL wall_lethal_pos got=(%0d,%0d) exp=(0,20)", px0, py0); end
        checks++; if (lost1 !== 1'b0) begin errors++; $display("FAIL wall_safe_lost got=%b exp=0", lost1); end
        checks++; if ({px1, py1, cnt1} !== {8'd0, 8'd20, 16'd0}) begin errors++; $display("FAIL wall_safe_pos got=(%0d,%0d,%0d) exp=(0,20,0)", px1, py1, cnt1); end
        press(4'b0001);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL dead_ignore_busy got=%b exp=0", busy0); end
        checks++; if (busy1 !== 1'b1) begin errors++; $display("FAIL safe_accept_busy got=%b exp=1", busy1); end
        repeat (2) @(posedge clk); #1;
        checks++; if ({px0, py0, lost0} !== {8'd0, 8'd20, 1'b1}) begin errors++; $display("FAIL dead_hold got=(%0d,%0d,%b) exp=(0,20,1)", px0, py0, lost0); end
        checks++; if ({px1, py1} !== {8'd0, 8'd19}) begin errors++; $display("FAIL safe_up got=(%0d,%0d) exp=(0,19)", px1, py1); end
        do_restart();
        checks++; if ({lost0, px0, py0} !== {1'b0, 8'd0, 8'd20}) begin errors++; $display("FAIL dead_restart got=(%b,%0d,%0d) exp=(0,0,20)", lost0, px0, py0); end
        clear_map();
    endtask

    task automatic test_bounds();
        press(4'b0100);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL bound_left_busy got=%b exp=0", busy0); end
        press(4'b0010);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL bound_down_busy got=%b exp=0", busy0); end
        repeat (2) @(posedge clk); #1;
        checks++; if ({px0, py0, cnt0} !== {8'd0, 8'd20, 16'd0}) begin errors++; $display("FAIL bound_pos got=(%0d,%0d,%0d) exp=(0,20,0)", px0, py0, cnt0); end
    endtask

    task automatic test_win();
        for (int i = 0; i < 29; i++) move(4'b1000);
        checks++; if ({px0, py0, won0} !== {8'd29, 8'd20, 1'b0}) begin errors++; $display("FAIL win_corner got=(%0d,%0d,%b) exp=(29,20,0)", px0, py0, won0); end
        press(4'b1000); // x+1 at MAP_W-1
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL bound_right_busy got=%b exp=0", busy0); end
        for (int i = 0; i < 20; i++) move(4'b0001);
        checks++; if ({px0, py0} !== {8'd29, 8'd0}) begin errors++; $display("FAIL win_pos got=(%0d,%0d) exp=(29,0)", px0, py0); end
        checks++; if ({won0, lost0, won1} !== 3'b101) begin errors++; $display("FAIL win_flags got=%b exp=101", {won0, lost0, won1}); end
        checks++; if (cnt0 !== 16'(49 * CE)) begin errors++; $display("FAIL win_count got=%0d exp=%0d", cnt0, 49 * CE); end
        press(4'b0100);
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL done_ignore_busy got=%b exp=0", busy0); end
        repeat (2) @(posedge clk); #1;
        checks++; if ({px0, py0, won0} !== {8'd29, 8'd0, 1'b1}) begin errors++; $display("FAIL done_hold got=(%0d,%0d,%b) exp=(29,0,1)", px0, py0, won0); end
        do_restart();
        checks++; if ({won0, px0, py0} !== {1'b0, 8'd0, 8'd20}) begin errors++; $display("FAIL done_restart got=(%b,%0d,%0d) exp=(0,0,20)", won0, px0, py0); end
    endtask

    task automatic test_reset_mid_move();
        press(4'b1000); // now in WAIT
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy0); end
        #2 reset = 1'b1;
        #1;
        checks++; if ({busy0, ma0} !== {1'b0, 5'd20}) begin errors++; $display("FAIL mid_async got=(%b,%0d) exp=(0,20)", busy0, ma0); end
        @(negedge clk) reset = 1'b0;
        repeat (4) @(posedge clk); #1;
        checks++; if ({px0, py0, cnt0, busy0} !== {8'd0, 8'd20, 16'd0, 1'b0}) begin errors++; $display("FAIL mid_no_commit got=(%0d,%0d,%0d,%b) exp=(0,20,0,0)", px0, py0, cnt0, busy0); end
    endtask

    initial begin
        test_reset();
        test_move_right();
        test_priority();
        test_wall();
        test_bounds();
        test_win();
        test_reset_mid_move();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
